// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the RV32I multi-cycle sequencer.
//   - opcode constants for the four supported instruction classes
//   - alu_op encodings driven towards the ALU control
//   - state_t, the sequencer state encoding (also exported on the debug port)
//   - branch_taken(), the BEQ/BNE resolution rule
package mc_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      EXEC_R = 4'd3,
      WB_R   = 4'd4,
      ADDR   = 4'd5,
      MEM_RD = 4'd6,
      MEM_WR = 4'd7,
      WB_LD  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   // BEQ (funct3=000) and BNE (funct3=001) only; any other funct3 never branches.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
      return ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
   endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// mc_mem_timer: wait counter for outstanding memory requests.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (counter clears to 0)
//   clr         restart the count (new request state entered, or abort)
//   active      a memory request is outstanding this cycle
//   ready       memory completes the request this cycle
//   expired     request has waited TIMEOUT cycles and memory is still not ready
// Parameters: TIMEOUT (0 disables expiry), CNT_W (2**CNT_W > TIMEOUT).
module mc_mem_timer #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic active,
   input  logic ready,
   output logic expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr || ready) begin
         cnt_d = '0;
      end else if (active) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q counts the waiting cycles already spent, so expiry fires on the
   // cycle after TIMEOUT waiting cycles; a ready in that cycle still wins.
   assign expired = (TIMEOUT != 0) && active && !ready && (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle sequencer for the RV32I datapath.
// Steps each instruction through FETCH/DECODE/execute/memory/writeback and
// decodes the datapath enables from the current state.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (state -> IDLE)
//   inst, zero       instruction register contents, ALU zero flag
//   mem_ready        memory completes the current request
//   mem_req, mem_we  memory request and its write qualifier
//   ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src_b, alu_op
//                    datapath controls
//   illegal, bus_err one-cycle pulses: unsupported opcode, memory timeout
//   state            current state, for debug
//   retired          (only with MC_SEQ_PERF_CNT_EN) completed-instruction count
// Optional feature macro: MC_SEQ_PERF_CNT_EN.
module mc_seq_ctrl
   import mc_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        alu_src_b,
   output logic [1:0]  alu_op,
   output logic        illegal,
   output logic        bus_err,
   output logic [3:0]  state
`ifdef MC_SEQ_PERF_CNT_EN
   ,
   output logic [31:0] retired
`endif
);

   state_t     state_q;
   state_t     state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       inst_unused;
   logic       timer_active;
   logic       timer_clr;
   logic       expired;

   assign opcode      = inst[6:0];
   assign funct3      = inst[14:12];
   assign inst_unused = ^{inst[31:15], inst[11:7]};

   // Derived from state_q alone so the timer never sees a combinational
   // path back through the next-state logic.
   assign timer_active = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
   // Any state change (or a timeout re-entering FETCH) restarts the count.
   assign timer_clr    = (state_d != state_q) || expired;

   mc_mem_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_mem_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .active  (timer_active),
      .ready   (mem_ready),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = ALU_ADD;
      illegal    = 1'b0;
      bus_err    = 1'b0;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end else if (expired) begin
               bus_err = 1'b1;
               state_d = FETCH;
            end
         end
         DECODE: begin
            case (opcode)
               OP_RTYPE:          state_d = EXEC_R;
               OP_LOAD, OP_STORE: state_d = ADDR;
               OP_BRANCH:         state_d = BRANCH;
               default: begin
                  illegal = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         EXEC_R: begin
            alu_op  = ALU_FUNC;
            state_d = WB_R;
         end
         WB_R: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end
         ADDR: begin
            alu_src_b = 1'b1;
            // inst is stable here since ir_write stays low after FETCH.
            if (opcode == OP_LOAD) begin
               state_d = MEM_RD;
            end else if (opcode == OP_STORE) begin
               state_d = MEM_WR;
            end else begin
               state_d = FETCH;
            end
         end
         MEM_RD: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               state_d = WB_LD;
            end else if (expired) begin
               bus_err = 1'b1;
               state_d = FETCH;
            end
         end
         MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ready) begin
               state_d = FETCH;
            end else if (expired) begin
               bus_err = 1'b1;
               state_d = FETCH;
            end
         end
         WB_LD: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = FETCH;
         end
         BRANCH: begin
            alu_op   = ALU_SUB;
            pc_src   = 1'b1;
            pc_write = branch_taken(funct3, zero);
            state_d  = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   assign state = state_q;

`ifdef MC_SEQ_PERF_CNT_EN
   logic        retire;
   logic [31:0] retired_q;
   logic [31:0] retired_d;

   // Only normal completions count; illegal and timeout exits are excluded.
   always_comb begin
      retire    = (state_q == WB_R) || (state_q == WB_LD) || (state_q == BRANCH) ||
                  ((state_q == MEM_WR) && mem_ready);
      retired_d = retired_q;
      if (retire) begin
         retired_d = retired_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;
`endif

endmodule

// File: doc/mc_seq_ctrl.md
Name: mc_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath driven by the main control unit.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Emits per-state datapath enables and handshakes memory through a req/ready pair.
- Handles the four opcode classes the control unit decodes: branch 1100011, store 0100011, R-type 0110011, load 0000011. All other opcodes are flagged illegal.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ready before aborting. 0 disables the timeout.
- CNT_W, 5, width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst  in  32  instruction register contents (opcode inst[6:0], funct3 inst[14:12]).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier for mem_req.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC (PC+4 in FETCH, target in BRANCH).
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  writeback source: 1 = memory data, 0 = ALU.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- bus_err  out  1  one-cycle pulse on memory timeout.
- state  out  4  current state encoding, for debug.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous, active-low.
- Reset drives state to IDLE. All outputs are 0 in IDLE. Wait counter clears to 0.
- Outputs are Moore-decoded from state, except pc_write in BRANCH, which also depends on zero/funct3.
- IDLE: go to FETCH on the first clock after reset deassertion.
- FETCH: mem_req=1, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: no enables asserted. Next state from inst[6:0]:
  - R-type -> EXEC_R.
  - load/store -> ADDR.
  - branch -> BRANCH.
  - anything else -> illegal=1 this cycle, then FETCH.
- EXEC_R: alu_src_b=0, alu_op=10, then WB_R.
- WB_R: reg_write=1, mem_to_reg=0, then FETCH.
- ADDR: alu_src_b=1, alu_op=00. Go to MEM_RD if load, MEM_WR if store. The opcode is re-read from inst, which holds stable because ir_write=0.
- MEM_RD: mem_req=1, mem_we=0. Go to WB_LD on mem_ready.
- MEM_WR: mem_req=1, mem_we=1. Go to FETCH on mem_ready.
- WB_LD: reg_write=1, mem_to_reg=1, then FETCH.
- BRANCH: alu_src_b=0, alu_op=01, pc_src=1, then FETCH.
  - pc_write = (funct3==000 & zero) | (funct3==001 & ~zero).
  - Other funct3 values: branch never taken, no error raised.
- Latency, zero-wait memory:
  - R-type 4 cycles.
  - load 5 cycles.
  - store 4 cycles.
  - branch 3 cycles.
- Wait counter:
  - Clears on entry to any mem_req state and whenever mem_ready=1.
  - Increments each cycle a request is outstanding.
  - When it reaches TIMEOUT (TIMEOUT>0): bus_err=1 for one cycle, the request drops, go to FETCH. ir_write, reg_write and pc_write stay 0.
- mem_ready outside a mem_req state is ignored.
- mem_ready and timeout in the same cycle: mem_ready wins, no bus_err.
- Reset mid-transaction: immediate return to IDLE. Outputs drop asynchronously and no partial writeback occurs.

Optional Feature:
- Macro: MC_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output retired [31:0], reset 0.
  - Increments on every transition into FETCH that completes an instruction: WB_R, WB_LD, MEM_WR with mem_ready, BRANCH.
  - Illegal and timeout exits do not count. The counter wraps at 2^32.
- Undefined: no port and no counter logic.

Decomposition:
- Package mc_pkg holds:
  - opcode constants OP_BRANCH, OP_STORE, OP_RTYPE, OP_LOAD.
  - alu_op constants ALU_ADD, ALU_SUB, ALU_FUNC.
  - state typedef/localparams: IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, MEM_WR, WB_LD, BRANCH.
- Sub-module mc_mem_timer holds the wait counter and timeout compare. It is instantiated once, with inputs clr/active/ready and output expired.

Test Plan:
- Reset release, R-type 0x00000033, mem_ready=1 always -> states IDLE, FETCH, DECODE, EXEC_R, WB_R, FETCH; reg_write=1 only in WB_R; each instruction takes 4 cycles.
- Load 0x00000003 with mem_ready low for 3 cycles in MEM_RD -> mem_req held 4 cycles; WB_LD asserts reg_write=1 with mem_to_reg=1.
- BEQ 0x00000063 with zero=1 then zero=0 -> pc_write=1, pc_src=1 in BRANCH on the first pass; pc_write=0 on the second. BNE 0x00001063 gives the inverse.
- Store 0x00000023 with mem_ready never asserted, TIMEOUT=16 -> bus_err pulse after 16 waiting cycles, return to FETCH, reg_write never asserted.
- Opcode 0x00000013 -> illegal pulses 1 cycle in DECODE, then FETCH; retired count is unchanged with MC_SEQ_PERF_CNT_EN defined.
- rst_n low during MEM_WR -> state=IDLE and mem_req=0 asynchronously before the next edge; after release the FETCH sequence restarts.
